dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the core load/store path and a debug/loader port. It grants at most one access per cycle, issues it to a synchronous memory with configurable read latency, and returns read data to the right requester through a tag pipeline. It also produces the core stall that gates the program counter while the core's memory access is blocked.

---
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with read tag pipeline and core stall
module dmem_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_prio_core,
    input  logic              i_c_req,
    input  logic              i_d_req,
    input  logic              i_c_we,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [31:0]       i_c_wdata,
    input  logic [31:0]       i_d_wdata,
    input  logic [3:0]        i_c_strb,
    input  logic [3:0]        i_d_strb,
    output logic              o_c_gnt,
    output logic              o_d_gnt,
    output logic              o_c_rvld,
    output logic              o_d_rvld,
    output logic [31:0]       o_c_rdata,
    output logic [31:0]       o_d_rdata,
    output logic              o_core_stall,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_strb,
    input  logic [31:0]       i_mem_rdata
);
    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_e;

    port_e             last_q, last_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_port_q, tag_port_d;
    logic              dbg_wins;
    logic              rd_issue;

    // Only consulted on contention; a lone requester always wins.
    always_comb begin
        if (i_prio_core) begin
            dbg_wins = (starve_q == CNT_MAX);
        end else begin
            dbg_wins = (last_q == PORT_CORE);
        end
    end

    assign o_c_gnt      = ~i_rst & i_c_req & ~(i_d_req & dbg_wins);
    assign o_d_gnt      = ~i_rst & i_d_req & ~(i_c_req & ~dbg_wins);
    assign o_core_stall = ~i_rst & i_c_req & ~o_c_gnt;
    assign o_mem_en     = o_c_gnt | o_d_gnt;

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_strb  = '0;
        if (o_c_gnt) begin
            o_mem_we    = i_c_we;
            o_mem_addr  = i_c_addr;
            o_mem_wdata = i_c_wdata;
            o_mem_strb  = i_c_strb;
        end else if (o_d_gnt) begin
            o_mem_we    = i_d_we;
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
            o_mem_strb  = i_d_strb;
        end
    end

    assign rd_issue = o_mem_en & ~o_mem_we;

    always_comb begin
        last_d = last_q;
        if (o_c_gnt) begin
            last_d = PORT_CORE;
        end else if (o_d_gnt) begin
            last_d = PORT_DBG;
        end

        if (i_d_req && !o_d_gnt) begin
            starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + 1'b1;
        end else begin
            starve_d = '0;
        end

        // Stage 0 is the newest tag; the top stage lines up with i_mem_rdata.
        tag_vld_d     = tag_vld_q << 1;
        tag_port_d    = tag_port_q << 1;
        tag_vld_d[0]  = rd_issue;
        tag_port_d[0] = o_d_gnt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q     <= PORT_DBG;
            starve_q   <= '0;
            tag_vld_q  <= '0;
            tag_port_q <= '0;
        end else begin
            last_q     <= last_d;
            starve_q   <= starve_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
        end
    end

    assign o_c_rvld  = tag_vld_q[RD_LAT-1] & ~tag_port_q[RD_LAT-1];
    assign o_d_rvld  = tag_vld_q[RD_LAT-1] & tag_port_q[RD_LAT-1];
    assign o_c_rdata = o_c_rvld ? i_mem_rdata : 32'd0;
    assign o_d_rdata = o_d_rvld ? i_mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter, one instance per read latency 1..4
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int          ADDR_W = 7;
    localparam int          SMAX   = 3;
    localparam int          NLAT   = 4;
    localparam logic [31:0] ALL    = (32'd1 << NLAT) - 32'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, prio, c_req, d_req, c_we, d_we;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [31:0]       c_wdata, d_wdata;
    logic [3:0]        c_strb, d_strb;

    logic [NLAT:1]              c_gnt, d_gnt, c_rvld, d_rvld, stall, mem_en, mem_we;
    logic [NLAT:1][31:0]        c_rdata, d_rdata, mem_wdata, rd_pipe;
    logic [NLAT:1][ADDR_W-1:0]  mem_addr;
    logic [NLAT:1][3:0]         mem_strb;

    for (genvar L = 1; L <= NLAT; L++) begin : g_dut
        dmem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(L), .STARVE_MAX(SMAX)) u_dut (
            .i_clk(clk), .i_rst(rst), .i_prio_core(prio),
            .i_c_req(c_req), .i_d_req(d_req), .i_c_we(c_we), .i_d_we(d_we),
            .i_c_addr(c_addr), .i_d_addr(d_addr),
            .i_c_wdata(c_wdata), .i_d_wdata(d_wdata),
            .i_c_strb(c_strb), .i_d_strb(d_strb),
            .o_c_gnt(c_gnt[L]), .o_d_gnt(d_gnt[L]),
            .o_c_rvld(c_rvld[L]), .o_d_rvld(d_rvld[L]),
            .o_c_rdata(c_rdata[L]), .o_d_rdata(d_rdata[L]),
            .o_core_stall(stall[L]),
            .o_mem_en(mem_en[L]), .o_mem_we(mem_we[L]), .o_mem_addr(mem_addr[L]),
            .o_mem_wdata(mem_wdata[L]), .o_mem_strb(mem_strb[L]),
            .i_mem_rdata(rd_pipe[L])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared synchronous memory; rd_pipe[k] is its output delayed to k cycles.
    logic [31:0] mem [0:31];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'h5A00_0000 | (i << 8) | i;
        for (int i = 0; i < 4; i++) mem[i] <= 32'hC0DE_0000 + i;
        mem[4] <= 32'hDEAD_BEEF;
        mem[8] <= 32'h1122_3344;
    end

    always @(posedge clk) begin
        for (int k = NLAT; k >= 2; k--) rd_pipe[k] <= rd_pipe[k-1];
        rd_pipe[1] <= 32'h0BAD_0BAD;
        if (mem_en[1]) begin
            if (mem_we[1]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_strb[1][b]) mem[mem_addr[1][ADDR_W-1:2]][8*b +: 8] <= mem_wdata[1][8*b +: 8];
            end else begin
                rd_pipe[1] <= mem[mem_addr[1][ADDR_W-1:2]];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Model: grant rules plus a per-cycle log of issued reads and reset cycles.
    int          m_last   = 1;
    int          m_starve = 0;
    bit          rd_vld  [0:1023];
    bit          rd_port [0:1023];
    logic [31:0] rd_data [0:1023];
    bit          rst_at  [0:1023];

    always @(negedge clk) begin
        int                t;
        logic              eg_c, eg_d, dbg, ev, ep, e_we;
        logic [31:0]       ed, e_wd;
        logic [ADDR_W-1:0] e_addr;
        logic [3:0]        e_strb;
        t = cyc;
        eg_c = 1'b0;
        eg_d = 1'b0;
        if (!rst) begin
            if (c_req && d_req) begin
                dbg  = prio ? (m_starve == SMAX) : (m_last == 0);
                eg_c = !dbg;
                eg_d = dbg;
            end else begin
                eg_c = c_req;
                eg_d = d_req;
            end
        end
        e_we   = eg_c ? c_we    : eg_d ? d_we    : 1'b0;
        e_addr = eg_c ? c_addr  : eg_d ? d_addr  : '0;
        e_wd   = eg_c ? c_wdata : eg_d ? d_wdata : '0;
        e_strb = eg_c ? c_strb  : eg_d ? d_strb  : '0;
        for (int k = 1; k <= NLAT; k++) begin
            chk($sformatf("c_gnt L%0d", k), 32'(c_gnt[k]), 32'(eg_c));
            chk($sformatf("d_gnt L%0d", k), 32'(d_gnt[k]), 32'(eg_d));
            chk($sformatf("stall L%0d", k), 32'(stall[k]), 32'(!rst && c_req && !eg_c));
            chk($sformatf("mem_en L%0d", k), 32'(mem_en[k]), 32'(eg_c || eg_d));
            chk($sformatf("mem_we L%0d", k), 32'(mem_we[k]), 32'(e_we));
            chk($sformatf("mem_addr L%0d", k), 32'(mem_addr[k]), 32'(e_addr));
            chk($sformatf("mem_wdata L%0d", k), mem_wdata[k], e_wd);
            chk($sformatf("mem_strb L%0d", k), 32'(mem_strb[k]), 32'(e_strb));
            if (t >= 1) begin
                ev = 1'b0;
                ep = 1'b0;
                ed = '0;
                if (t - k >= 0 && rd_vld[t-k]) begin
                    ev = 1'b1;
                    ep = rd_port[t-k];
                    ed = rd_data[t-k];
                    for (int r = t - k + 1; r < t; r++) if (rst_at[r]) ev = 1'b0;
                end
                chk($sformatf("c_rvld L%0d", k), 32'(c_rvld[k]), 32'(ev && !ep));
                chk($sformatf("d_rvld L%0d", k), 32'(d_rvld[k]), 32'(ev && ep));
                chk($sformatf("c_rdata L%0d", k), c_rdata[k], (ev && !ep) ? ed : 32'd0);
                chk($sformatf("d_rdata L%0d", k), d_rdata[k], (ev && ep) ? ed : 32'd0);
            end
        end
        if (rst) begin
            m_last   = 1;
            m_starve = 0;
            rst_at[t] = 1'b1;
        end else begin
            if (eg_c) m_last = 0;
            else if (eg_d) m_last = 1;
            if (d_req && !eg_d) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            else m_starve = 0;
            if ((eg_c || eg_d) && !e_we) begin
                rd_vld[t]  = 1'b1;
                rd_port[t] = eg_d;
                rd_data[t] = mem[e_addr[ADDR_W-1:2]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic req, input logic we, input int a, input logic [31:0] wd, input logic [3:0] s);
        c_req = req; c_we = we; c_addr = ADDR_W'(a); c_wdata = wd; c_strb = s;
    endtask

    task automatic set_d(input logic req, input logic we, input int a, input logic [31:0] wd, input logic [3:0] s);
        d_req = req; d_we = we; d_addr = ADDR_W'(a); d_wdata = wd; d_strb = s;
    endtask

    task automatic idle();
        set_c(1'b0, 1'b0, 0, 32'd0, 4'd0);
        set_d(1'b0, 1'b0, 0, 32'd0, 4'd0);
    endtask

    initial begin
        prio = 1'b0;
        rst  = 1'b1;
        set_c(1'b1, 1'b0, 'h10, 32'd0, 4'd0);
        set_d(1'b1, 1'b0, 'h04, 32'd0, 4'd0);
        @(negedge clk);
        chk("reset c_gnt", 32'(c_gnt), 32'd0);
        chk("reset d_gnt", 32'(d_gnt), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset mem_en", 32'(mem_en), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr c_gnt", 32'(c_gnt), (i % 2 == 0) ? ALL : 32'd0);
            chk("rr d_gnt", 32'(d_gnt), (i % 2 == 1) ? ALL : 32'd0);
            chk("rr stall", 32'(stall), (i % 2 == 1) ? ALL : 32'd0);
            tick();
        end
        idle();
        repeat (6) tick();

        set_c(1'b1, 1'b0, 'h10, 32'd0, 4'd0);
        @(negedge clk);
        chk("single c_gnt", 32'(c_gnt), ALL);
        tick();
        idle();
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            for (int k = 1; k <= NLAT; k++) begin
                chk($sformatf("single c_rvld L%0d +%0d", k, j), 32'(c_rvld[k]), 32'(j == k));
                chk($sformatf("single c_rdata L%0d +%0d", k, j), c_rdata[k], (j == k) ? 32'hDEAD_BEEF : 32'd0);
                chk($sformatf("single d_rvld L%0d +%0d", k, j), 32'(d_rvld[k]), 32'd0);
            end
            tick();
        end

        prio = 1'b1;
        set_c(1'b1, 1'b0, 'h10, 32'd0, 4'd0);
        set_d(1'b1, 1'b0, 'h04, 32'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fixed c_gnt", 32'(c_gnt), (i % 4 != 3) ? ALL : 32'd0);
            chk("fixed d_gnt", 32'(d_gnt), (i % 4 == 3) ? ALL : 32'd0);
            chk("fixed stall", 32'(stall), (i % 4 == 3) ? ALL : 32'd0);
            tick();
        end
        idle();
        repeat (6) tick();

        set_d(1'b1, 1'b1, 'h20, 32'hFFFF_FFA5, 4'b0001);
        @(negedge clk);
        chk("wr d_gnt", 32'(d_gnt), ALL);
        chk("wr mem_we", 32'(mem_we), ALL);
        chk("wr mem_strb", 32'(mem_strb[1]), 32'h1);
        tick();
        idle();
        set_c(1'b1, 1'b0, 'h20, 32'd0, 4'd0);
        @(negedge clk);
        chk("rd c_gnt", 32'(c_gnt), ALL);
        chk("wr no d_rvld", 32'(d_rvld), 32'd0);
        tick();
        idle();
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            for (int k = 1; k <= NLAT; k++) begin
                chk($sformatf("wr-rd c_rvld L%0d +%0d", k, j), 32'(c_rvld[k]), 32'(j == k));
                chk($sformatf("wr-rd c_rdata L%0d +%0d", k, j), c_rdata[k], (j == k) ? 32'h1122_33A5 : 32'd0);
                chk($sformatf("wr-rd d_rvld L%0d +%0d", k, j), 32'(d_rvld[k]), 32'd0);
            end
            tick();
        end

        for (int i = 0; i < 4; i++) begin
            set_c(1'b1, 1'b0, i * 4, 32'd0, 4'd0);
            @(negedge clk);
            chk("pipe c_gnt", 32'(c_gnt), ALL);
            tick();
        end
        idle();
        for (int j = 4; j <= 8; j++) begin
            @(negedge clk);
            chk($sformatf("pipe c_rvld L4 +%0d", j), 32'(c_rvld[4]), 32'(j <= 7));
            chk($sformatf("pipe c_rdata L4 +%0d", j), c_rdata[4], (j <= 7) ? 32'hC0DE_0000 + 32'(j - 4) : 32'd0);
            tick();
        end
        repeat (2) tick();

        prio = 1'b0;
        set_c(1'b1, 1'b0, 'h10, 32'd0, 4'd0);
        @(negedge clk);
        chk("flight c_gnt 0", 32'(c_gnt), ALL);
        tick();
        set_c(1'b1, 1'b0, 'h04, 32'd0, 4'd0);
        @(negedge clk);
        chk("flight c_gnt 1", 32'(c_gnt), ALL);
        tick();
        rst = 1'b1;
        set_c(1'b1, 1'b1, 'h30, 32'h3030_3030, 4'hF);
        set_d(1'b1, 1'b1, 'h34, 32'h3434_3434, 4'hF);
        @(negedge clk);
        chk("mid-rst c_gnt", 32'(c_gnt), 32'd0);
        chk("mid-rst d_gnt", 32'(d_gnt), 32'd0);
        chk("mid-rst stall", 32'(stall), 32'd0);
        chk("mid-rst mem_en", 32'(mem_en), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst tie c_gnt", 32'(c_gnt), ALL);
        chk("post-rst tie d_gnt", 32'(d_gnt), 32'd0);
        chk("post-rst c_rvld +1", 32'(c_rvld), 32'd0);
        chk("post-rst d_rvld +1", 32'(d_rvld), 32'd0);
        tick();
        @(negedge clk);
        chk("post-rst alt d_gnt", 32'(d_gnt), ALL);
        chk("post-rst c_rvld +2", 32'(c_rvld), 32'd0);
        chk("post-rst d_rvld +2", 32'(d_rvld), 32'd0);
        tick();
        idle();
        repeat (2) tick();

        for (int i = 0; i < 24; i++) begin
            prio = ((i / 6) % 2) == 1;
            set_c((i % 3) != 2, (i % 5) == 0, i * 4, 32'hC000_0000 | i, 4'hF);
            set_d((i % 4) != 1, (i % 7) == 3, i * 12 + 8, 32'hD000_0000 | i, 4'(i + 1));
            tick();
        end
        idle();
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
